fpadd_scheduler: RTL and testbench
==================================

FPADD_SCHEDULER -- requirements
Module: fpadd_scheduler

Interface
REQ-001 SHALL have parameter ADD_LAT, default 3: fixed cycle latency of the downstream adder, from add_issue to add_result valid; legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each: the requester presents an operand pair.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 each: the operand pair is accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 each: IEEE-754 single-precision operands.
REQ-008 SHALL have port add_issue, output, 1: the operand pair is launched into the adder.
REQ-009 SHALL have ports add_a / add_b, output, 32 each: the launched operands.
REQ-010 SHALL have port add_result, input, 32: adder sum, valid exactly ADD_LAT cycles after add_issue.
REQ-011 SHALL have ports rsp0_valid / rsp1_valid, output, 1 each: a result is returned to that requester.
REQ-012 SHALL have port rsp_data, output, 32: the returned sum, shared by both requesters.
REQ-013 SHALL have port drain_req, input, 1: stop accepting requests and empty the pipe.
REQ-014 SHALL have port drain_done, output, 1: one-cycle pulse when the drain completes.
REQ-015 SHALL have port busy, output, 1: high while any operation is in flight.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DRAIN; it SHALL move IDLE->RUN on any reqN_valid while drain_req is low.
REQ-017 SHALL move RUN->IDLE when no request is valid and the in-flight count is 0.
REQ-018 SHALL move to DRAIN from IDLE or RUN when drain_req is high; drain_req has priority over new requests in the same cycle.
REQ-019 SHALL, in DRAIN, hold req0_ready and req1_ready low.
REQ-020 SHALL, in DRAIN, pulse drain_done for one cycle in the cycle the in-flight count is 0, then go to IDLE.
REQ-021 SHALL, in IDLE or RUN, grant at most one requester per cycle by round-robin using a 1-bit priority pointer (reset value 0 = req0 favoured).
REQ-022 SHALL assert reqN_ready only for the granted requester; handshake completes when reqN_valid and reqN_ready are both high.
REQ-023 SHALL toggle the pointer to the non-granted requester after each grant; the pointer holds when there is no grant.
REQ-024 SHALL drive add_issue combinationally equal to the handshake, with add_a/add_b equal to the granted operands.
REQ-025 SHALL carry a tag {valid, id} in an ADD_LAT-deep shift register advanced every cycle.
REQ-026 SHALL, in the cycle the tag emerges, assert rspN_valid for tag id N and drive rsp_data = add_result; responses SHALL NOT be back-pressured.
REQ-027 SHALL keep the in-flight count at 0..ADD_LAT; +1 on issue, -1 on emerge, net 0 on simultaneous issue and emerge.
REQ-028 SHALL drive busy = (in-flight count != 0).
REQ-029 SHALL allow back-to-back issue every cycle; throughput is 1 operation per cycle.

Reset
REQ-030 SHALL, on rst, set state IDLE, pointer 0, all tags invalid and count 0.
REQ-031 SHALL, on rst, drive ready, add_issue, rspN_valid, drain_done and busy to 0; rsp_data is 0 when no rspN_valid is high.
REQ-032 SHALL, on rst mid-operation, drop in-flight results with no response.

Configuration
REQ-033 SHALL, with FPADD_SCHED_STATS_EN defined, add output ports grant0_cnt and grant1_cnt (CNT_W each), reset to 0, incremented per handshake and saturating at all-ones.
REQ-034 SHALL, without FPADD_SCHED_STATS_EN, omit those ports and counters entirely.

Verification
REQ-035 SHALL test a single request: req0 with a=0x3F800000, b=0x40000000 -> add_issue in the same cycle, rsp0_valid exactly 3 cycles later with rsp_data = the adder output (0x40400000 with the reference adder).
REQ-036 SHALL test contention: both valid continuously for 4 cycles from reset -> grants in order 0,1,0,1, and responses in the same order at cycles +3..+6.
REQ-037 SHALL test drain: drain_req high with 2 operations in flight -> ready=0 immediately, drain_done pulses in the cycle the count reaches 0, then state IDLE.
REQ-038 SHALL test reset mid-flight: rst with 3 operations in flight -> no rspN_valid afterwards, busy=0, and next grant goes to req0.
REQ-039 SHALL test stats with FPADD_SCHED_STATS_EN and CNT_W=2: 5 grants to req1 -> grant1_cnt saturates at 3.

Source files
------------

// File: rtl/fpadd_scheduler.sv
// Purpose: round-robin arbiter that issues operand pairs from two requesters into a fixed-latency FP adder and routes each sum back.
// Latency: add_issue in the same cycle as the handshake; rspN_valid exactly ADD_LAT cycles after that issue.
// Backpressure: one grant per cycle, ready withheld while draining; responses are never back-pressured. Optional stats: FPADD_SCHED_STATS_EN.
module fpadd_scheduler #(
    parameter int ADD_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        add_issue,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_result,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    input  logic        drain_req,
    output logic        drain_done,
    output logic        busy
`ifdef FPADD_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    localparam int CW = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state, stateNext;
    logic                 prioPtr;
    logic [ADD_LAT-1:0]   tagVld;
    logic [ADD_LAT-1:0]   tagId;
    logic [CW-1:0]        inFlight;
    logic                 grantVld;
    logic                 grantId;
    logic                 emerge;

    // Round-robin grant; nothing is granted while draining, when a drain is requested, or in reset.
    always_comb begin
        grantVld = 1'b0;
        grantId  = 1'b0;
        if (!rst && !drain_req && state != DRAIN) begin
            if (!prioPtr) begin
                if (req0_valid) begin
                    grantVld = 1'b1;
                    grantId  = 1'b0;
                end else if (req1_valid) begin
                    grantVld = 1'b1;
                    grantId  = 1'b1;
                end
            end else begin
                if (req1_valid) begin
                    grantVld = 1'b1;
                    grantId  = 1'b1;
                end else if (req0_valid) begin
                    grantVld = 1'b1;
                    grantId  = 1'b0;
                end
            end
        end
    end

    // Handshake, adder launch and response routing; the oldest tag marks the cycle add_result is valid.
    always_comb begin
        req0_ready = grantVld && !grantId;
        req1_ready = grantVld && grantId;
        add_issue  = grantVld;
        add_a      = grantId ? req1_a : req0_a;
        add_b      = grantId ? req1_b : req0_b;
        emerge     = tagVld[ADD_LAT-1] && !rst;
        rsp0_valid = emerge && !tagId[ADD_LAT-1];
        rsp1_valid = emerge && tagId[ADD_LAT-1];
        rsp_data   = emerge ? add_result : 32'h0;
        busy       = (inFlight != '0) && !rst;
    end

    // Next-state logic; drain_req outranks new requests and drain_done fires once the pipe is empty.
    always_comb begin
        stateNext  = state;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (drain_req) begin
                    stateNext = DRAIN;
                end else if (req0_valid || req1_valid) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (drain_req) begin
                    stateNext = DRAIN;
                end else if (!req0_valid && !req1_valid && inFlight == '0) begin
                    stateNext = IDLE;
                end
            end
            DRAIN: begin
                if (inFlight == '0) begin
                    drain_done = !rst;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, priority pointer, tag pipe and in-flight count; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prioPtr  <= 1'b0;
            tagVld   <= '0;
            tagId    <= '0;
            inFlight <= '0;
        end else begin
            state     <= stateNext;
            if (grantVld) begin
                prioPtr <= ~grantId;
            end
            tagVld[0] <= grantVld;
            tagId[0]  <= grantId;
            for (int i = 1; i < ADD_LAT; i++) begin
                tagVld[i] <= tagVld[i-1];
                tagId[i]  <= tagId[i-1];
            end
            case ({grantVld, tagVld[ADD_LAT-1]})
                2'b10:   inFlight <= inFlight + CW'(1);
                2'b01:   inFlight <= inFlight - CW'(1);
                default: inFlight <= inFlight;
            endcase
        end
    end

`ifdef FPADD_SCHED_STATS_EN
    // Per-requester handshake counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (grantVld && !grantId && grant0_cnt != '1) begin
                grant0_cnt <= grant0_cnt + CNT_W'(1);
            end
            if (grantVld && grantId && grant1_cnt != '1) begin
                grant1_cnt <= grant1_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpadd_scheduler.sv
// Purpose: directed, table-driven checks of fpadd_scheduler: single op, contention, drain, reset mid-flight, optional stats.
// Latency: the bench adder model returns the IEEE sum ADD_LAT cycles after add_issue.
// Backpressure: inputs driven 1ns after posedge, outputs compared at negedge.
module tb_fpadd_scheduler;

    localparam int ADD_LAT = 3;
`ifdef FPADD_SCHED_STATS_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif

    localparam logic [31:0] Z    = 32'h0000_0000;
    localparam logic [31:0] QTR  = 32'h3E80_0000;
    localparam logic [31:0] HALF = 32'h3F00_0000;
    localparam logic [31:0] P75  = 32'h3F40_0000;
    localparam logic [31:0] ONE  = 32'h3F80_0000;
    localparam logic [31:0] ONEH = 32'h3FC0_0000;
    localparam logic [31:0] TWO  = 32'h4000_0000;
    localparam logic [31:0] THR  = 32'h4040_0000;
    localparam logic [31:0] FOUR = 32'h4080_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        add_issue;
    logic [31:0] add_a, add_b, add_result;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic        drain_req = 1'b0;
    logic        drain_done, busy;
`ifdef FPADD_SCHED_STATS_EN
    logic [TB_CNT_W-1:0] grant0_cnt, grant1_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpadd_scheduler #(.ADD_LAT(ADD_LAT), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .add_issue(add_issue), .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
`ifdef FPADD_SCHED_STATS_EN
        , .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
`endif
    );

    // Reference adder: single-precision sum through reals, valid ADD_LAT cycles after issue.
    function automatic real f2r(input logic [31:0] f);
        real m;
        if (f[30:0] == 31'h0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        m = m * (2.0 ** (real'(int'(f[30:23])) - 127.0));
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] de;
        if (r == 0.0) return 32'h0;
        d  = $realtobits(r);
        de = d[62:52];
        return {d[63], 8'(de - 11'd896), d[51:29]};
    endfunction

    logic [31:0] pipe [ADD_LAT];
    always @(posedge clk) begin
        pipe[0] <= add_issue ? r2f(f2r(add_a) + f2r(add_b)) : 32'h0;
        for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_result = pipe[ADD_LAT-1];

    typedef struct {
        bit          rst, v0, v1, dr;
        logic [31:0] a0, b0, a1, b1;
        bit          r0, r1, iss;
        logic [31:0] ea, eb;
        bit          s0, s1;
        logic [31:0] ed;
        bit          bz, dn;
    } row_t;

    row_t tbl[$];

    task automatic addRow(input bit rs, v0, v1, dr, input logic [31:0] a0, b0, a1, b1,
                          input bit r0, r1, iss, input logic [31:0] ea, eb,
                          input bit s0, s1, input logic [31:0] ed, input bit bz, dn);
        row_t r;
        r = '{rs, v0, v1, dr, a0, b0, a1, b1, r0, r1, iss, ea, eb, s0, s1, ed, bz, dn};
        tbl.push_back(r);
    endtask

    task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    initial begin
        // Single request from reset (reset rows hold req0_valid high to show ready stays low).
        addRow(1,1,0,0, ONE,TWO,Z,Z,  0,0,0, Z,Z,     0,0,Z,    0,0);
        addRow(1,1,0,0, ONE,TWO,Z,Z,  0,0,0, Z,Z,     0,0,Z,    0,0);
        addRow(0,1,0,0, ONE,TWO,Z,Z,  1,0,1, ONE,TWO, 0,0,Z,    0,0);
        addRow(0,0,0,0, Z,Z,Z,Z,      0,0,0, Z,Z,     0,0,Z,    1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,      0,0,0, Z,Z,     0,0,Z,    1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,      0,0,0, Z,Z,     1,0,THR,  1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,      0,0,0, Z,Z,     0,0,Z,    0,0);
        // Contention from reset: grants 0,1,0,1, responses in the same order three cycles later.
        addRow(1,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,     0,0,Z,    0,0);
        addRow(0,1,1,0, ONE,ONE,TWO,TWO,   1,0,1, ONE,ONE, 0,0,Z,    0,0);
        addRow(0,1,1,0, ONE,ONE,TWO,TWO,   0,1,1, TWO,TWO, 0,0,Z,    1,0);
        addRow(0,1,1,0, ONE,ONE,TWO,TWO,   1,0,1, ONE,ONE, 0,0,Z,    1,0);
        addRow(0,1,1,0, ONE,ONE,TWO,TWO,   0,1,1, TWO,TWO, 1,0,TWO,  1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,     0,1,FOUR, 1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,     1,0,TWO,  1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,     0,1,FOUR, 1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,     0,0,Z,    0,0);
        // Drain: priority over a request in IDLE, then drain with two ops in flight.
        addRow(1,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,       0,0,Z,    0,0);
        addRow(0,1,0,1, HALF,QTR,Z,Z,      0,0,0, Z,Z,       0,0,Z,    0,0);
        addRow(0,1,0,0, HALF,QTR,Z,Z,      0,0,0, Z,Z,       0,0,Z,    0,1);
        addRow(0,1,0,0, HALF,QTR,Z,Z,      1,0,1, HALF,QTR,  0,0,Z,    0,0);
        addRow(0,0,1,0, Z,Z,ONEH,HALF,     0,1,1, ONEH,HALF, 0,0,Z,    1,0);
        addRow(0,1,1,1, ONE,ONE,ONE,ONE,   0,0,0, Z,Z,       0,0,Z,    1,0);
        addRow(0,1,0,0, ONE,ONE,Z,Z,       0,0,0, Z,Z,       1,0,P75,  1,0);
        addRow(0,1,0,0, ONE,ONE,Z,Z,       0,0,0, Z,Z,       0,1,TWO,  1,0);
        addRow(0,1,0,0, ONE,ONE,Z,Z,       0,0,0, Z,Z,       0,0,Z,    0,1);
        addRow(0,1,0,0, ONE,TWO,Z,Z,       1,0,1, ONE,TWO,   0,0,Z,    0,0);
        // Reset with three ops in flight: no responses survive, pointer back to req0.
        addRow(1,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,       0,0,Z,    0,0);
        addRow(0,1,1,0, ONE,ONE,TWO,TWO,   1,0,1, ONE,ONE,   0,0,Z,    0,0);
        addRow(0,1,1,0, ONE,ONE,TWO,TWO,   0,1,1, TWO,TWO,   0,0,Z,    1,0);
        addRow(0,1,1,0, ONE,ONE,TWO,TWO,   1,0,1, ONE,ONE,   0,0,Z,    1,0);
        addRow(1,1,1,0, ONE,ONE,TWO,TWO,   0,0,0, Z,Z,       0,0,Z,    0,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,       0,0,Z,    0,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,       0,0,Z,    0,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,       0,0,Z,    0,0);
        addRow(0,1,1,0, HALF,HALF,ONE,ONE, 1,0,1, HALF,HALF, 0,0,Z,    0,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,       0,0,Z,    1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,       0,0,Z,    1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,       1,0,ONE,  1,0);
        addRow(0,0,0,0, Z,Z,Z,Z,           0,0,0, Z,Z,       0,0,Z,    0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst        = tbl[i].rst;
            req0_valid = tbl[i].v0;
            req1_valid = tbl[i].v1;
            drain_req  = tbl[i].dr;
            req0_a     = tbl[i].a0;
            req0_b     = tbl[i].b0;
            req1_a     = tbl[i].a1;
            req1_b     = tbl[i].b1;
            @(negedge clk);
            check("req0_ready", i, 32'(req0_ready), 32'(tbl[i].r0));
            check("req1_ready", i, 32'(req1_ready), 32'(tbl[i].r1));
            check("add_issue",  i, 32'(add_issue),  32'(tbl[i].iss));
            if (tbl[i].iss) begin
                check("add_a", i, add_a, tbl[i].ea);
                check("add_b", i, add_b, tbl[i].eb);
            end
            check("rsp0_valid", i, 32'(rsp0_valid), 32'(tbl[i].s0));
            check("rsp1_valid", i, 32'(rsp1_valid), 32'(tbl[i].s1));
            check("rsp_data",   i, rsp_data,        tbl[i].ed);
            check("busy",       i, 32'(busy),       32'(tbl[i].bz));
            check("drain_done", i, 32'(drain_done), 32'(tbl[i].dn));
        end

`ifdef FPADD_SCHED_STATS_EN
        // Five back-to-back grants to req1 with a 2-bit counter: 1,2,3,3,3.
        @(posedge clk);
        #1;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; drain_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("grant1_cnt_rst", 100, 32'(grant1_cnt), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            req1_valid = 1'b1;
            req1_a = ONE;
            req1_b = ONE;
            @(posedge clk);
            #1;
            req1_valid = 1'b0;
            @(negedge clk);
            check("grant1_cnt", 100 + k, 32'(grant1_cnt), (k < 3) ? 32'(k) : 32'd3);
            check("grant0_cnt", 100 + k, 32'(grant0_cnt), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
